// File: rtl/nib_arb_pkg.sv
// Shared types and constants for the nibble-priority arbiter.
// Also holds the saturating effective-priority helper.
package nib_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int AGE_W = 4;
  localparam int NIB_W = 4;

  localparam logic [1:0] ID_A = 2'd0;
  localparam logic [1:0] ID_B = 2'd1;
  localparam logic [1:0] ID_C = 2'd2;
  localparam logic [1:0] ID_D = 2'd3;

  // The 5-bit sum keeps the carry so it can be clamped to the nibble maximum.
  function automatic logic [NIB_W-1:0] sat_eff(input logic [NIB_W-1:0] nib,
                                               input logic [AGE_W-1:0] age);
    logic [NIB_W:0] sum;
    sum = {1'b0, nib} + {1'b0, age};
    if (sum[NIB_W]) begin
      sat_eff = 4'd15;
    end else begin
      sat_eff = sum[NIB_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nib_max4.sv
// Combinational four-way maximum with a rotating tie-break start point.
// Scans upward from i_rr_ptr; a strictly larger value is needed to displace the earlier candidate.
module nib_max4
  import nib_arb_pkg::*;
(
  input  logic [NIB_W-1:0] i_eff_a,
  input  logic [NIB_W-1:0] i_eff_b,
  input  logic [NIB_W-1:0] i_eff_c,
  input  logic [NIB_W-1:0] i_eff_d,
  input  logic [3:0]       i_req,
  input  logic [1:0]       i_rr_ptr,
  output logic [1:0]       o_idx,
  output logic [NIB_W-1:0] o_val,
  output logic             o_any
);

  logic [NIB_W-1:0] w_eff [4];

  assign w_eff[0] = i_eff_a;
  assign w_eff[1] = i_eff_b;
  assign w_eff[2] = i_eff_c;
  assign w_eff[3] = i_eff_d;

  // Rotating scan keeping the first maximum seen
  always_comb begin
    logic [1:0] w_i;
    logic       w_take;
    o_idx  = i_rr_ptr;
    o_val  = 4'd0;
    o_any  = 1'b0;
    w_i    = 2'd0;
    w_take = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_i    = i_rr_ptr + 2'(k);
      w_take = i_req[w_i] && (!o_any || (w_eff[w_i] > o_val));
      o_idx  = w_take ? w_i : o_idx;
      o_val  = w_take ? w_eff[w_i] : o_val;
      o_any  = o_any || w_take;
    end
  end

endmodule

// File: rtl/nib_arb.sv
// Four-requester arbiter: largest aged priority nibble wins, with grant hold limit,
// round-robin tie-break and per-requester aging of waiting requesters.
module nib_arb
  import nib_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int AGE_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [3:0]       req,
  input  logic [NIB_W-1:0] nibble_A,
  input  logic [NIB_W-1:0] nibble_B,
  input  logic [NIB_W-1:0] nibble_C,
  input  logic [NIB_W-1:0] nibble_D,
  input  logic             done,
  output logic [3:0]       gnt,
  output logic [1:0]       id_mayor,
  output logic [NIB_W-1:0] nibble_mayor,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           r_state;
  logic [7:0]       r_hold_cnt;
  logic [1:0]       r_rr_ptr;
  logic [7:0]       r_wait [4];
  logic [AGE_W-1:0] r_age  [4];
  logic [3:0]       r_gnt;
  logic [1:0]       r_id_mayor;
  logic [NIB_W-1:0] r_nibble_mayor;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic [NIB_W-1:0] w_nib [4];
  logic [NIB_W-1:0] w_eff [4];
  logic [1:0]       w_win_idx;
  logic [NIB_W-1:0] w_win_val;
  logic             w_any;
  logic             w_hold_lim;
  logic             w_req_win;
  logic             w_release;
  logic             w_force;

  assign w_nib[0] = nibble_A;
  assign w_nib[1] = nibble_B;
  assign w_nib[2] = nibble_C;
  assign w_nib[3] = nibble_D;

  // Effective priorities from nibble plus age
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_eff[i] = sat_eff(w_nib[i], r_age[i]);
    end
  end

  nib_max4 u_max (
    .i_eff_a  (w_eff[0]),
    .i_eff_b  (w_eff[1]),
    .i_eff_c  (w_eff[2]),
    .i_eff_d  (w_eff[3]),
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_idx    (w_win_idx),
    .o_val    (w_win_val),
    .o_any    (w_any)
  );

  assign w_hold_lim = (r_hold_cnt == 8'(MAX_HOLD - 1));
  assign w_req_win  = req[r_id_mayor];
  assign w_release  = (r_state == GRANT) && (done || !w_req_win || w_hold_lim);
  // A timeout is only flagged when nothing else would have ended the grant.
  assign w_force    = (r_state == GRANT) && w_hold_lim && !done && w_req_win;

  // Grant FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state        <= IDLE;
      r_hold_cnt     <= 8'd0;
      r_rr_ptr       <= 2'd0;
      r_gnt          <= 4'd0;
      r_id_mayor     <= ID_A;
      r_nibble_mayor <= 4'd0;
      r_gnt_valid    <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_any) begin
            r_gnt          <= 4'b0001 << w_win_idx;
            r_id_mayor     <= w_win_idx;
            r_nibble_mayor <= w_win_val;
            r_gnt_valid    <= 1'b1;
            r_hold_cnt     <= 8'd0;
            r_state        <= GRANT;
          end else begin
            r_gnt       <= 4'd0;
            r_gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_gnt       <= 4'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= w_force;
            r_rr_ptr    <= r_id_mayor + 2'd1;
            r_state     <= IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
            r_timeout  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt       <= 4'd0;
          r_gnt_valid <= 1'b0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester wait counters and ages; the current holder is frozen until released
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_L || !req[i] || (w_release && (r_id_mayor == 2'(i)))) begin
        r_wait[i] <= 8'd0;
        r_age[i]  <= 4'd0;
      end else if (r_gnt[i]) begin
        r_wait[i] <= r_wait[i];
        r_age[i]  <= r_age[i];
      end else if (r_wait[i] == 8'(AGE_PERIOD - 1)) begin
        r_wait[i] <= 8'd0;
        r_age[i]  <= (r_age[i] == 4'd15) ? r_age[i] : r_age[i] + 4'd1;
      end else begin
        r_wait[i] <= r_wait[i] + 8'd1;
        r_age[i]  <= r_age[i];
      end
    end
  end

  assign gnt          = r_gnt;
  assign id_mayor     = r_id_mayor;
  assign nibble_mayor = r_nibble_mayor;
  assign gnt_valid    = r_gnt_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_nib_arb.sv
// Self-checking bench for nib_arb: directed scenarios plus random traffic,
// each cycle compared against a behavioural arbitration model.
module tb_nib_arb;

  localparam int MAX_HOLD   = 8;
  localparam int AGE_PERIOD = 4;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] req;
  logic [3:0] nibble_A, nibble_B, nibble_C, nibble_D;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] id_mayor;
  logic [3:0] nibble_mayor;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_busy = 1'b0;
  bit m_to   = 1'b0;
  int m_id   = 0;
  int m_nib  = 0;
  int m_held = 0;
  int m_rr   = 0;
  int m_age  [4] = '{0, 0, 0, 0};
  int m_wait [4] = '{0, 0, 0, 0};

  nib_arb #(.MAX_HOLD(MAX_HOLD), .AGE_PERIOD(AGE_PERIOD)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .req          (req),
    .nibble_A     (nibble_A),
    .nibble_B     (nibble_B),
    .nibble_C     (nibble_C),
    .nibble_D     (nibble_D),
    .done         (done),
    .gnt          (gnt),
    .id_mayor     (id_mayor),
    .nibble_mayor (nibble_mayor),
    .gnt_valid    (gnt_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] m_vec();
    logic [3:0] g;
    g = m_busy ? (4'b0001 << m_id) : 4'b0000;
    return {g, 2'(m_id), 4'(m_nib), m_busy, m_to};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {gnt, id_mayor, nibble_mayor, gnt_valid, timeout};
  endfunction

  // One clock of the arbitration rules, using the inputs present before the edge.
  task automatic model_tick();
    int nb [4];
    int eff [4];
    int best;
    int win;
    nb[0] = nibble_A; nb[1] = nibble_B; nb[2] = nibble_C; nb[3] = nibble_D;
    if (!reset_L) begin
      m_busy = 1'b0; m_to = 1'b0; m_id = 0; m_nib = 0; m_held = 0; m_rr = 0;
      for (int i = 0; i < 4; i++) begin m_age[i] = 0; m_wait[i] = 0; end
      return;
    end
    for (int i = 0; i < 4; i++) begin
      eff[i] = nb[i] + m_age[i];
      if (eff[i] > 15) eff[i] = 15;
    end
    for (int i = 0; i < 4; i++) begin
      if (!req[i]) begin
        m_age[i] = 0; m_wait[i] = 0;
      end else if (!(m_busy && m_id == i)) begin
        m_wait[i]++;
        if (m_wait[i] == AGE_PERIOD) begin
          m_wait[i] = 0;
          if (m_age[i] < 15) m_age[i]++;
        end
      end
    end
    if (m_busy) begin
      if (done || !req[m_id] || m_held == MAX_HOLD) begin
        m_to   = (m_held == MAX_HOLD) && !done && req[m_id];
        m_busy = 1'b0;
        m_rr   = (m_id + 1) % 4;
        m_age[m_id]  = 0;
        m_wait[m_id] = 0;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end else begin
      m_to = 1'b0;
      if (req != 4'd0) begin
        best = -1;
        for (int i = 0; i < 4; i++) if (req[i] && eff[i] > best) best = eff[i];
        win = -1;
        for (int i = 0; i < 4; i++) begin
          if (req[i] && eff[i] == best &&
              (win < 0 || ((i - m_rr + 4) % 4) < ((win - m_rr + 4) % 4))) win = i;
        end
        m_busy = 1'b1; m_id = win; m_nib = eff[win]; m_held = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; req = 4'd0; done = 1'b0;
    nibble_A = 4'd0; nibble_B = 4'd0; nibble_C = 4'd0; nibble_D = 4'd0;
    step();
    step();
    total++;
    if (dut_vec() !== 12'h000) begin
      bad++; $display("FAIL reset outputs: got %h want %h", dut_vec(), 12'h000);
    end
    reset_L = 1'b1;
    step();
    total++;
    if (dut_vec() !== m_vec()) begin
      bad++; $display("FAIL reset idle: got %h want %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_basic_max();
    nibble_A = 4'd3; nibble_B = 4'd9; nibble_C = 4'd5; nibble_D = 4'd1;
    req = 4'b1111; done = 1'b0;
    step();
    total++;
    if ({gnt, id_mayor, nibble_mayor, gnt_valid} !== {4'b0010, 2'd1, 4'd9, 1'b1}) begin
      bad++; $display("FAIL basic grant: got %h want %h", dut_vec(), {4'b0010, 2'd1, 4'd9, 1'b1, 1'b0});
    end
    step();
    done = 1'b1;
    step();
    total++;
    if (dut_vec() !== {4'b0000, 2'd1, 4'd9, 1'b0, 1'b0}) begin
      bad++; $display("FAIL basic release: got %h want %h", dut_vec(), {4'b0000, 2'd1, 4'd9, 1'b0, 1'b0});
    end
    done = 1'b0; req = 4'd0;
    step();
    total++;
    if (dut_vec() !== m_vec()) begin
      bad++; $display("FAIL basic idle: got %h want %h", dut_vec(), m_vec());
    end
  endtask

  task automatic test_rr_tie();
    int exp_id [4] = '{2, 3, 0, 1};
    nibble_A = 4'd7; nibble_B = 4'd7; nibble_C = 4'd7; nibble_D = 4'd7;
    req = 4'b1111; done = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      total++;
      if (!gnt_valid || id_mayor !== 2'(exp_id[n]) || gnt !== (4'b0001 << exp_id[n])) begin
        bad++; $display("FAIL rr grant %0d: got gnt=%b id=%0d want id=%0d", n, gnt, id_mayor, exp_id[n]);
      end
      step();
      total++;
      if (gnt_valid !== 1'b0 || gnt !== 4'd0 || dut_vec() !== m_vec()) begin
        bad++; $display("FAIL rr idle %0d: got %h want %h", n, dut_vec(), m_vec());
      end
    end
    req = 4'd0; done = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    nibble_D = 4'd4; req = 4'b1000; done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (c <= 8 && (gnt !== 4'b1000 || timeout !== 1'b0)) begin
        bad++; $display("FAIL timeout hold %0d: got gnt=%b to=%b want gnt=1000 to=0", c, gnt, timeout);
      end else if (c == 9 && (gnt !== 4'b0000 || timeout !== 1'b1)) begin
        bad++; $display("FAIL timeout pulse: got gnt=%b to=%b want gnt=0000 to=1", gnt, timeout);
      end else if (c == 10 && (gnt !== 4'b1000 || timeout !== 1'b0)) begin
        bad++; $display("FAIL timeout regrant: got gnt=%b to=%b want gnt=1000 to=0", gnt, timeout);
      end else if (dut_vec() !== m_vec()) begin
        bad++; $display("FAIL timeout model %0d: got %h want %h", c, dut_vec(), m_vec());
      end
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_aging();
    int found = 0;
    nibble_A = 4'd10; nibble_B = 4'd2; req = 4'b0011; done = 1'b0;
    for (int n = 1; n <= 60 && found == 0; n++) begin
      step();
      total++;
      if (dut_vec() !== m_vec()) begin
        bad++; $display("FAIL aging model %0d: got %h want %h", n, dut_vec(), m_vec());
      end
      if (gnt[1] === 1'b1) found = n;
    end
    total++;
    if (found != 37 || nibble_mayor !== 4'd11) begin
      bad++; $display("FAIL aging B win: got cycle=%0d nib=%0d want cycle=37 nib=11", found, nibble_mayor);
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_saturation();
    int found = 0;
    nibble_C = 4'd14; nibble_D = 4'd15; req = 4'b1100; done = 1'b0;
    for (int n = 1; n <= 40 && found == 0; n++) begin
      step();
      total++;
      if (dut_vec() !== m_vec()) begin
        bad++; $display("FAIL sat model %0d: got %h want %h", n, dut_vec(), m_vec());
      end
      if (gnt[2] === 1'b1) found = n;
    end
    total++;
    if (found != 10 || nibble_mayor !== 4'd15 || id_mayor !== 2'd2) begin
      bad++; $display("FAIL sat C win: got cycle=%0d nib=%0d id=%0d want cycle=10 nib=15 id=2", found, nibble_mayor, id_mayor);
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    nibble_A = 4'd5; nibble_B = 4'd5; nibble_C = 4'd2; nibble_D = 4'd5;
    req = 4'b1111; done = 1'b0;
    for (int n = 0; n < 6; n++) step();
    total++;
    if (gnt_valid !== 1'b1 || dut_vec() !== m_vec()) begin
      bad++; $display("FAIL midrst pre: got %h want %h", dut_vec(), m_vec());
    end
    reset_L = 1'b0;
    step();
    total++;
    if (dut_vec() !== 12'h000) begin
      bad++; $display("FAIL midrst clear: got %h want %h", dut_vec(), 12'h000);
    end
    reset_L = 1'b1;
    step();
    total++;
    if (dut_vec() !== {4'b0001, 2'd0, 4'd5, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midrst regrant: got %h want %h", dut_vec(), {4'b0001, 2'd0, 4'd5, 1'b1, 1'b0});
    end
    req = 4'd0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      reset_L = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        nibble_A = 4'($urandom); nibble_B = 4'($urandom);
        nibble_C = 4'($urandom); nibble_D = 4'($urandom);
      end
      done = ($urandom_range(0, 5) == 0);
      step();
      total++;
      if (dut_vec() !== m_vec()) begin
        bad++; $display("FAIL random %0d: got %h want %h", n, dut_vec(), m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_max();
    test_rr_tie();
    test_timeout();
    test_aging();
    test_saturation();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nib_arb.md
Name: nib_arb

Overview:
- Four-requester arbiter that grants a shared resource to the requester with the largest priority nibble.
- Sequential layer around the nibble-maximum selection: grant holding, timeout, aging of waiting requesters, and round-robin tie-breaking.
- Sits between the four nibble sources (A..D) and the shared downstream consumer.

Parameters:
- MAX_HOLD, 8: maximum cycles a grant may be held before forced release; legal range 1..255.
- AGE_PERIOD, 4: cycles of continuous waiting per +1 age increment; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset_L  input  1  synchronous reset, active low
- req  input  4  request per requester; bit0=A, bit1=B, bit2=C, bit3=D
- nibble_A  input  4  priority of requester A
- nibble_B  input  4  priority of requester B
- nibble_C  input  4  priority of requester C
- nibble_D  input  4  priority of requester D
- done  input  1  granted requester releases the resource
- gnt  output  4  one-hot grant, registered
- id_mayor  output  2  index of granted requester, registered
- nibble_mayor  output  4  effective priority of the winner at decision time, registered
- gnt_valid  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset is synchronous: reset_L=0 at a rising edge clears everything.
  - All outputs go to 0.
  - State goes to IDLE; rr_ptr, all ages and hold_cnt go to 0.
  - Reset asserted during GRANT drops gnt at that same edge.
- Effective priority: eff_i = min(15, nibble_i + age_i), 5-bit add then saturate. Only requesters with req_i=1 compete.
- Winner selection:
  - Maximum eff among competing requesters.
  - Ties go to the first index at or after rr_ptr, scanning upward mod 4.
- State IDLE:
  - If any req bit is set, the winner is registered: gnt, id_mayor, nibble_mayor, gnt_valid=1; hold_cnt=0; state goes to GRANT.
  - Latency is 1 cycle from req to gnt.
  - If req=0, outputs hold at 0.
- State GRANT:
  - Nibble inputs are ignored; nibble_mayor is frozen.
  - hold_cnt increments each cycle.
  - Release at the next edge when any of these holds: done=1; req[id_mayor]=0; hold_cnt==MAX_HOLD-1.
  - timeout=1 for one cycle only when release is caused by the hold limit and done=0 and req[id_mayor]=1. If done arrives on the same cycle as the hold limit, it is a normal release with no timeout.
- On release:
  - gnt and gnt_valid go to 0; nibble_mayor and id_mayor keep their last value.
  - rr_ptr = id_mayor+1 mod 4.
  - Winner's age clears to 0.
  - State returns to IDLE.
  - One mandatory idle cycle separates consecutive grants, so the earliest next grant is the edge after the release edge.
- Aging:
  - Per requester: 8-bit wait counter and 4-bit age.
  - While req_i=1 and i is not granted, the wait counter increments. At AGE_PERIOD-1 it wraps to 0 and age_i increments, saturating at 15.
  - req_i=0 clears both the wait counter and age_i.
  - Aging continues during other requesters' grants.
- Full hold: with MAX_HOLD=1, every grant lasts exactly one cycle, and timeout pulses unless done=1 or the request dropped.
- Only one gnt bit is ever set.

Decomposition:
- Package nib_arb_pkg holds:
  - State encoding localparams: IDLE=1'b0, GRANT=1'b1.
  - AGE_W=4, NIB_W=4.
  - Requester index constants: ID_A..ID_D.
- Sub-module nib_max4, purely combinational:
  - Inputs: four eff values, req mask, rr_ptr.
  - Outputs: winner index, winner value, any.
  - Reused by the IDLE decision logic.
- Top level holds the FSM, hold counter, age counters and output registers.

Test Plan:
- Basic max
  - Stimulus: reset; req=4'b1111, nibbles A=3, B=9, C=5, D=1; done at cycle 3.
  - Required: gnt=4'b0010, id_mayor=1, nibble_mayor=9 one cycle after req. gnt drops after done. rr_ptr=2.
- Round-robin tie
  - Stimulus: all nibbles=7, req=4'b1111; assert done each grant.
  - Required: grant order C, D, A, B after the first grant to B (rr_ptr=2 from the previous test). One idle cycle between grants.
- Timeout
  - Stimulus: MAX_HOLD=8; requester D alone, done=0, req held.
  - Required: gnt=4'b1000 for exactly 8 cycles; timeout pulses once with the release; regrant to D after one idle cycle.
- Aging
  - Stimulus: AGE_PERIOD=4; A nibble=10 held granted via repeated grants; B nibble=2 waiting.
  - Required: B's age reaches 8 after 32 waiting cycles (eff_B=10). B wins the next tie if rr_ptr favours it. B wins outright once eff_B=11.
- Saturation
  - Stimulus: nibble=14, long wait.
  - Required: eff capped at 15; nibble_mayor=15.
- Reset mid-grant
  - Stimulus: reset_L=0 during GRANT.
  - Required: at that edge all outputs 0, ages 0; after reset_L=1 with req held, a fresh grant occurs one cycle later.
